// File: rtl/ifetch_queue.sv
// ifetch_queue: decoupled instruction fetch front end.
// Owns the fetch PC, issues credit-limited requests to instruction memory,
// buffers in-order responses in a DEPTH-entry queue for decode, and flushes
// wrong-path work (including in-flight responses) on a resolved redirect.
// Optional build macro IFETCH_QUEUE_PERF_EN adds perf_fetched, perf_dropped
// and perf_redirects event counters.
module ifetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redir_valid,
  input  logic            redir_sel,
  input  logic [XLEN-1:0] redir_pc,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] alu,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
`ifdef IFETCH_QUEUE_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_redirects,
`endif
  output logic [XLEN-1:0] if_instr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding_nxt;
  logic            credit_ok;
  logic            grant;
  logic            dropping;
  logic            push;
  logic            pop;

  // Redirect target; low two bits are cleared so fetch stays word aligned.
  always_comb begin
    target      = redir_sel ? alu : redir_pc + offset;
    target[1:0] = 2'b00;
  end

  // Handshake decode: credits cover both queued and in-flight instructions,
  // so a response can never find the queue full.
  always_comb begin
    credit_ok       = (SW'({1'b0, count}) + SW'({1'b0, outstanding})) < SW'(DEPTH);
    imem_req        = reset && !redir_valid && credit_ok && (drop_cnt == '0);
    imem_addr       = fetch_pc;
    grant           = imem_req && imem_gnt;
    dropping        = imem_rvalid && (redir_valid || (drop_cnt != '0));
    push            = imem_rvalid && !dropping;
    if_valid        = (count != '0) && !redir_valid;
    pop             = if_valid && if_ready;
    outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);
    if_pc           = q_pc[rd_ptr];
    if_instr        = q_instr[rd_ptr];
    if_pc4          = q_pc[rd_ptr] + XLEN'(4);
  end

  // PC tracking and request/response bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redir_valid) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redir_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; entries reset so the idle head reads RESET_PC / 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]    <= RESET_PC;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IFETCH_QUEUE_PERF_EN
  // Event counters: pushed responses, discarded responses, redirect cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= '0;
      perf_dropped   <= '0;
      perf_redirects <= '0;
    end else begin
      perf_fetched   <= perf_fetched + 32'(push);
      perf_dropped   <= perf_dropped + 32'(dropping);
      perf_redirects <= perf_redirects + 32'(redir_valid);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and randomized checks of ifetch_queue against a
// transaction-level model (pending-request list with stale flags, decode queue).
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redir_valid = 1'b0;
  logic        redir_sel = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] offset = '0;
  logic [31:0] alu = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
`ifdef IFETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_redirects;
`endif

  ifetch_queue #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_pc(redir_pc),
    .offset(offset), .alu(alu),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pc4(if_pc4),
`ifdef IFETCH_QUEUE_PERF_EN
    .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
    .perf_redirects(perf_redirects),
`endif
    .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        m_pend[$];
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc;
  int          m_pops, m_pushes, m_drops, m_redirs;
  int          n_checks = 0;
  int          n_fail = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  function automatic bit exp_req();
    int st = 0;
    foreach (m_pend[i]) if (m_pend[i].stale) st++;
    return reset && !redir_valid && (m_q.size() + m_pend.size() < DEPTH) && (st == 0);
  endfunction

  function automatic bit exp_valid();
    return (m_q.size() > 0) && !redir_valid;
  endfunction

  task automatic model_reset();
    m_pend.delete(); m_q.delete();
    m_fetch_pc = RPC;
    m_pops = 0; m_pushes = 0; m_drops = 0; m_redirs = 0;
  endtask

  // Drive one cycle's inputs; a response is only offered when a request is pending.
  task automatic set_in(input bit gnt, input bit rv, input bit rdy, input bit rd,
                        input bit sel, input logic [31:0] rpc, input logic [31:0] off,
                        input logic [31:0] a);
    imem_gnt = gnt; if_ready = rdy; redir_valid = rd; redir_sel = sel;
    redir_pc = rpc; offset = off; alu = a;
    if (rv && m_pend.size() > 0) begin
      imem_rvalid = 1'b1; imem_rdata = instr_of(m_pend[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
  endtask

  // Advance the model by the current cycle's inputs, then move to the next negedge.
  task automatic step();
    req_t r; ent_t e; bit gr, pop, push; logic [31:0] t;
    gr = exp_req() && imem_gnt;
    pop = exp_valid() && if_ready;
    push = 1'b0;
    if (imem_rvalid) begin
      r = m_pend.pop_front();
      push = !redir_valid && !r.stale;
      if (push) m_pushes++; else m_drops++;
    end
    if (redir_valid) begin
      m_redirs++;
      m_q.delete();
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
      t = redir_sel ? alu : redir_pc + offset;
      t[1:0] = 2'b00;
      m_fetch_pc = t;
    end else begin
      if (pop) begin m_q.delete(0); m_pops++; end
      if (push) begin e.pc = r.addr; e.instr = instr_of(r.addr); m_q.push_back(e); end
      if (gr) begin r.addr = m_fetch_pc; r.stale = 1'b0; m_pend.push_back(r); m_fetch_pc += 32'd4; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1, 0, 1, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
    n_checks++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr got %h want %h", imem_addr, RPC); end
    n_checks++; if (if_pc !== RPC) begin n_fail++; $display("FAIL reset_if_pc got %h want %h", if_pc, RPC); end
    n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr got %h want 0", if_instr); end
`ifdef IFETCH_QUEUE_PERF_EN
    n_checks++; if ({perf_fetched, perf_dropped, perf_redirects} !== 96'h0) begin
      n_fail++; $display("FAIL reset_perf got %h %h %h want 0", perf_fetched, perf_dropped, perf_redirects); end
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b want 1", imem_req); end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] exp_out; int first_v;
    do_reset();
    exp_out = RPC; first_v = -1;
    for (int i = 0; i < 12; i++) begin
      set_in(1, 1, 1, 0, 0, 0, 0, 0);
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== RPC + 32'(4 * i)) begin
        n_fail++; $display("FAIL stream_addr c%0d got %b/%h want 1/%h", i, imem_req, imem_addr, RPC + 32'(4 * i)); end
      if (if_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        n_checks++; if (if_pc !== exp_out || if_instr !== instr_of(exp_out) || if_pc4 !== exp_out + 32'd4) begin
          n_fail++; $display("FAIL stream_head got %h/%h/%h want %h/%h/%h", if_pc, if_instr, if_pc4,
                             exp_out, instr_of(exp_out), exp_out + 32'd4); end
        exp_out += 32'd4;
      end
      step();
    end
    n_checks++; if (first_v != 2) begin n_fail++; $display("FAIL stream_first_valid got cycle %0d want 2", first_v); end
    n_checks++; if (exp_out !== 32'd40) begin n_fail++; $display("FAIL stream_pops got next pc %h want 28", exp_out); end
  endtask

  task automatic test_backpressure();
    int grants, grants2;
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      if (imem_req && imem_gnt) grants++;
      step();
    end
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (grants != 4) begin n_fail++; $display("FAIL bp_grants got %0d want 4", grants); end
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_full got req %b valid %b want 0/1", imem_req, if_valid); end
    n_checks++; if (if_pc !== RPC) begin n_fail++; $display("FAIL bp_head got %h want %h", if_pc, RPC); end
    set_in(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    step();
    grants2 = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      if (imem_req && imem_gnt) grants2++;
      step();
    end
    n_checks++; if (grants2 != 1) begin n_fail++; $display("FAIL bp_refill got %0d grants want 1", grants2); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL bp_head2 got %h want 4", if_pc); end
  endtask

  task automatic test_branch_redirect();
    bit seen;
    do_reset();
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 1, 0, 0, 0, 0, 0); #1; step(); end
    set_in(1, 0, 1, 1, 0, 32'h100, 32'hFFFF_FFF0, 32'h0);
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL br_redir_cycle got req %b valid %b want 0/0", imem_req, if_valid); end
    step();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 1, 0, 0, 0, 0, 0);
      #1;
      n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'hF0 || if_valid !== 1'b0) begin
        n_fail++; $display("FAIL br_drain%0d got req %b addr %h valid %b want 0/f0/0", i, imem_req, imem_addr, if_valid); end
      step();
    end
    set_in(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) begin
      n_fail++; $display("FAIL br_newpath got req %b addr %h want 1/f0", imem_req, imem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++; if (if_pc !== 32'hF0 || if_instr !== instr_of(32'hF0)) begin
          n_fail++; $display("FAIL br_first_pc got %h/%h want f0/%h", if_pc, if_instr, instr_of(32'hF0)); end
      end
      step();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL br_timeout got no valid want valid within 8 cycles"); end
`ifdef IFETCH_QUEUE_PERF_EN
    n_checks++; if (perf_redirects !== 32'd1 || perf_dropped !== 32'd2) begin
      n_fail++; $display("FAIL br_perf got redir %0d drop %0d want 1/2", perf_redirects, perf_dropped); end
    n_checks++; if (perf_fetched !== 32'(m_pops + m_q.size())) begin
      n_fail++; $display("FAIL br_perf_fetched got %0d want %0d", perf_fetched, m_pops + m_q.size()); end
`endif
  endtask

  task automatic test_jalr_redirect();
    bit seen;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0); #1; step();
    set_in(1, 1, 0, 0, 0, 0, 0, 0); #1; step();
    set_in(0, 1, 1, 1, 1, 32'h40, 32'h8, 32'h203);
    #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL jalr_cycle got valid %b req %b rvalid %b want 0/0/1", if_valid, imem_req, imem_rvalid); end
    step();
    set_in(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL jalr_next got req %b addr %h valid %b want 1/200/0", imem_req, imem_addr, if_valid); end
    step();
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      set_in(1, 1, 1, 0, 0, 0, 0, 0);
      #1;
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++; if (if_pc !== 32'h200 || if_pc4 !== 32'h204) begin
          n_fail++; $display("FAIL jalr_first_pc got %h/%h want 200/204", if_pc, if_pc4); end
      end
      step();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL jalr_timeout got no valid want valid within 8 cycles"); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin set_in(1, 1, 0, 0, 0, 0, 0, 0); #1; step(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (imem_req !== 1'b1 || if_valid !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre got req %b valid %b want 1/1", imem_req, if_valid); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL ar_async got req %b valid %b want 0/0", imem_req, if_valid); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RPC || if_pc !== RPC || if_instr !== 32'h0) begin
      n_fail++; $display("FAIL ar_restart got req %b addr %h pc %h instr %h want 1/%h/%h/0",
                         imem_req, imem_addr, if_pc, if_instr, RPC, RPC); end
    step();
  endtask

  task automatic test_random();
    bit er, ev;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(2, 0) != 0,
             $urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1, $urandom, $urandom, $urandom);
      #1;
      er = exp_req();
      ev = exp_valid();
      n_checks++; if (imem_req !== er || imem_addr !== m_fetch_pc) begin
        n_fail++; $display("FAIL rnd_req c%0d got %b/%h want %b/%h", i, imem_req, imem_addr, er, m_fetch_pc); end
      n_checks++; if (if_valid !== ev) begin
        n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", i, if_valid, ev); end
      if (ev) begin
        n_checks++; if (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr || if_pc4 !== m_q[0].pc + 32'd4) begin
          n_fail++; $display("FAIL rnd_head c%0d got %h/%h/%h want %h/%h/%h", i, if_pc, if_instr, if_pc4,
                             m_q[0].pc, m_q[0].instr, m_q[0].pc + 32'd4); end
      end
      step();
      n_checks++; if (m_q.size() > DEPTH) begin
        n_fail++; $display("FAIL rnd_overflow c%0d got occupancy %0d want <= %0d", i, m_q.size(), DEPTH); end
    end
`ifdef IFETCH_QUEUE_PERF_EN
    n_checks++; if (perf_fetched !== 32'(m_pushes) || perf_dropped !== 32'(m_drops) || perf_redirects !== 32'(m_redirs)) begin
      n_fail++; $display("FAIL rnd_perf got %0d/%0d/%0d want %0d/%0d/%0d", perf_fetched, perf_dropped,
                         perf_redirects, m_pushes, m_drops, m_redirs); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_redirect();
    test_jalr_redirect();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
